// File: rtl/receptor_ascii_pkg.sv
// Shared types and constants for the 7E2 serial ASCII message receiver.
package receptor_ascii_pkg;

  localparam int DATA_BITS = 7;
  localparam int STOP_BITS = 2;
  localparam logic LINE_IDLE = 1'b1;

  // One encoding for both the message FSM and the character sequencer,
  // so a single debug port can show whichever one is active.
  typedef enum logic [3:0] {
    ESPERA_INICIO = 4'd0,
    PREPARA       = 4'd1,
    OCIOSO        = 4'd2,
    START         = 4'd3,
    DADOS         = 4'd4,
    PARIDADE      = 4'd5,
    STOP1         = 4'd6,
    STOP2         = 4'd7,
    ARMAZENA      = 4'd8,
    FIM           = 4'd9
  } estado_t;

  // Even parity holds when data bits plus parity bit carry an even number of ones.
  function automatic logic paridade_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return ~(^{d, p});
  endfunction

endpackage

// File: rtl/receptor_serial_7E2.sv
// Character sequencer: synchronizes the line, times bits and deframes one
// 7E2 character at a time. Handshake: o_valido is a 1-cycle strobe; o_char,
// o_par_ok and o_stop_ok are held stable from that strobe until the next
// character's data bits start shifting, so the consumer may read them in any
// cycle of that window. Clearing i_habilita aborts any character in progress.
module receptor_serial_7E2
  import receptor_ascii_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_habilita,
  input  logic                 i_serial,
  output logic [DATA_BITS-1:0] o_char,
  output logic                 o_par_ok,
  output logic                 o_stop_ok,
  output logic                 o_valido,
  output logic [3:0]           o_estado
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_FIM  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_MEIO = CW'(CLKS_PER_BIT / 2 - 1);

  logic                 r_sync1, r_sync2;
  estado_t              r_estado;
  logic [CW-1:0]        r_cnt;
  logic [2:0]           r_nbit;
  logic [DATA_BITS-1:0] r_dados;
  logic                 r_par_ok, r_stop_ok, r_valido;

  logic          w_bit;
  logic          w_fim_bit;
  logic [CW-1:0] w_cnt_prox;

  assign w_bit      = r_sync2;
  assign w_fim_bit  = (r_cnt == C_FIM);
  assign w_cnt_prox = w_fim_bit ? '0 : r_cnt + 1'b1;

  // Two-stage synchronizer for the asynchronous line, parked at idle level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= LINE_IDLE;
      r_sync2 <= LINE_IDLE;
    end else begin
      r_sync1 <= i_serial;
      r_sync2 <= r_sync1;
    end
  end

  // Start detection, mid-bit sampling of data/parity/stops, valid strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado  <= OCIOSO;
      r_cnt     <= '0;
      r_nbit    <= '0;
      r_dados   <= '0;
      r_par_ok  <= 1'b1;
      r_stop_ok <= 1'b1;
      r_valido  <= 1'b0;
    end else begin
      r_valido <= 1'b0;
      if (!i_habilita) begin
        r_estado <= OCIOSO;
        r_cnt    <= '0;
      end else begin
        case (r_estado)
          OCIOSO: begin
            r_cnt  <= '0;
            r_nbit <= '0;
            if (w_bit == 1'b0) r_estado <= START;
          end
          START: begin
            if (r_cnt == C_MEIO) begin
              r_cnt    <= '0;
              r_estado <= (w_bit == 1'b0) ? DADOS : OCIOSO;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          DADOS: begin
            r_cnt <= w_cnt_prox;
            if (w_fim_bit) begin
              r_dados <= {w_bit, r_dados[DATA_BITS-1:1]};
              r_nbit  <= r_nbit + 1'b1;
              if (r_nbit == 3'(DATA_BITS - 1)) r_estado <= PARIDADE;
            end
          end
          PARIDADE: begin
            r_cnt <= w_cnt_prox;
            if (w_fim_bit) begin
              r_par_ok <= paridade_ok(r_dados, w_bit);
              r_estado <= STOP1;
            end
          end
          STOP1: begin
            r_cnt <= w_cnt_prox;
            if (w_fim_bit) begin
              r_stop_ok <= w_bit;
              r_estado  <= STOP2;
            end
          end
          STOP2: begin
            r_cnt <= w_cnt_prox;
            if (w_fim_bit) begin
              r_stop_ok <= r_stop_ok & w_bit;
              r_valido  <= 1'b1;
              r_estado  <= OCIOSO;
            end
          end
          default: r_estado <= OCIOSO;
        endcase
      end
    end
  end

  assign o_char    = r_dados;
  assign o_par_ok  = r_par_ok;
  assign o_stop_ok = r_stop_ok;
  assign o_valido  = r_valido;
  assign o_estado  = 4'(r_estado);

endmodule

// File: rtl/receptor_ascii.sv
// Receives an N-character message over the 7E2 line and presents it as a
// parallel buffer, with a completion pulse and sticky error flags.
module receptor_ascii
  import receptor_ascii_pkg::*;
#(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     iniciar,
  input  logic                     dado_serial,
  output logic [7*N-1:0]           dados_ascii,
  output logic                     pronto,
  output logic                     recebendo,
  output logic                     erro_paridade,
  output logic                     erro_frame,
  output logic [$clog2(N+1)-1:0]   indice,
  output logic [3:0]               estado
);

  localparam int IW = $clog2(N + 1);

  estado_t              r_estado;
  logic [7*N-1:0]       r_dados;
  logic                 r_pronto, r_recebendo, r_erro_par, r_erro_frame;
  logic [IW-1:0]        r_indice;

  logic                 w_habilita;
  logic [DATA_BITS-1:0] w_char;
  logic                 w_par_ok, w_stop_ok, w_valido;
  logic [3:0]           w_sub_estado;

  // The sequencer keeps running through ARMAZENA so a back-to-back start
  // bit arriving right after STOP2 is not lost.
  assign w_habilita = (r_estado == OCIOSO) || (r_estado == ARMAZENA);

  receptor_serial_7E2 #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_serial (
    .clock     (clock),
    .reset     (reset),
    .i_habilita(w_habilita),
    .i_serial  (dado_serial),
    .o_char    (w_char),
    .o_par_ok  (w_par_ok),
    .o_stop_ok (w_stop_ok),
    .o_valido  (w_valido),
    .o_estado  (w_sub_estado)
  );

  // Message FSM with its datapath: arming, storage, index, flags, done pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado     <= ESPERA_INICIO;
      r_dados      <= '0;
      r_pronto     <= 1'b0;
      r_recebendo  <= 1'b0;
      r_erro_par   <= 1'b0;
      r_erro_frame <= 1'b0;
      r_indice     <= '0;
    end else begin
      r_pronto <= 1'b0;
      if (iniciar) begin
        // Arming always wins; a partial character is dropped by the sequencer.
        r_estado     <= PREPARA;
        r_indice     <= '0;
        r_erro_par   <= 1'b0;
        r_erro_frame <= 1'b0;
        r_recebendo  <= 1'b1;
      end else begin
        case (r_estado)
          ESPERA_INICIO: r_estado <= ESPERA_INICIO;
          PREPARA:       r_estado <= OCIOSO;
          OCIOSO:        if (w_valido) r_estado <= ARMAZENA;
          ARMAZENA: begin
            for (int k = 0; k < N; k++) begin
              if (r_indice == IW'(k)) r_dados[7*k +: 7] <= w_char;
            end
            if (r_indice != IW'(N)) r_indice <= r_indice + 1'b1;
            if (!w_par_ok)  r_erro_par   <= 1'b1;
            if (!w_stop_ok) r_erro_frame <= 1'b1;
            if (r_indice == IW'(N - 1)) begin
              r_estado    <= FIM;
              r_pronto    <= 1'b1;
              r_recebendo <= 1'b0;
            end else begin
              r_estado <= OCIOSO;
            end
          end
          FIM:     r_estado <= ESPERA_INICIO;
          default: r_estado <= ESPERA_INICIO;
        endcase
      end
    end
  end

  assign dados_ascii   = r_dados;
  assign pronto        = r_pronto;
  assign recebendo     = r_recebendo;
  assign erro_paridade = r_erro_par;
  assign erro_frame    = r_erro_frame;
  assign indice        = r_indice;
  assign estado        = (r_estado == OCIOSO) ? w_sub_estado : 4'(r_estado);

endmodule
